acc_stream: RTL and testbench

Parametrised, streaming successor to the task-2 Sobel accelerator. Reads a packed 8-bit greyscale image of IMG_W x IMG_H pixels from the shared 32-bit word memory in raster order, reading every input word exactly once. Buffers a sliding window of past words internally, applies a 3x3 Sobel kernel four pixels at a time, and writes a same-size edge image at OUT_BASE. It sits in the accelerator slot behind the start/finish handshake driven by the test controller.

---
 rtl/acc_stream.sv | 174 +++++++++++++++++
 tb/tb_acc_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_stream.sv
// acc_stream: streaming 3x3 Sobel edge filter over a packed 8-bit greyscale image.
// Reads each input word once, keeps a sliding history of 2*WW+2 words and writes
// one output word per input word, lagging WW+1 words behind the read stream.
// Optional feature macro: ACC_THRESH_EN (adds the thresh port and binarises the output).
module acc_stream #(
  parameter int unsigned IMG_W    = 352,
  parameter int unsigned IMG_H    = 288,
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned OUT_BASE = 25344
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] addr,
  input  logic [31:0] dataR,
  output logic [31:0] dataW,
  output logic        en,
  output logic        we,
  input  logic        start,
  output logic        finish
`ifdef ACC_THRESH_EN
  ,
  input  logic [7:0]  thresh
`endif
);

  localparam int unsigned WW = IMG_W / 4;
  localparam int unsigned NW = IMG_H * WW;
  localparam int unsigned HD = 2 * WW + 2;
  localparam int unsigned CW = $clog2(NW + 1);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned LW = $clog2(WW);

  typedef enum logic [2:0] {IDLE, RD, WR, FLUSH, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   k;
  logic [CW-1:0]   m;
  logic [RW-1:0]   orow;
  logic [LW-1:0]   ocol;
  logic            wr;
  logic [31:0]     cur;
  logic [31:0]     hist [HD];
  logic [47:0]     strip_t, strip_m, strip_b;
  logic [31:0]     out_word;

  // 3x3 Sobel magnitude for one pixel, saturated to 8 bits
  function automatic logic [7:0] sobel3x3(input logic [7:0] tl, input logic [7:0] tc,
                                          input logic [7:0] tr, input logic [7:0] ml,
                                          input logic [7:0] mr, input logic [7:0] bl,
                                          input logic [7:0] bc, input logic [7:0] br);
    logic signed [11:0] gx, gy;
    logic [11:0]        ax, ay, sum;
    gx  = $signed({4'h0, tr}) + $signed({3'h0, mr, 1'b0}) + $signed({4'h0, br})
        - $signed({4'h0, tl}) - $signed({3'h0, ml, 1'b0}) - $signed({4'h0, bl});
    gy  = $signed({4'h0, bl}) + $signed({3'h0, bc, 1'b0}) + $signed({4'h0, br})
        - $signed({4'h0, tl}) - $signed({3'h0, tc, 1'b0}) - $signed({4'h0, tr});
    ax  = gx[11] ? 12'(-gx) : 12'(gx);
    ay  = gy[11] ? 12'(-gy) : 12'(gy);
    sum = ax + ay;
    return (sum > 12'd255) ? 8'hFF : sum[7:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and memory-port outputs
  always_comb begin
    state_next = state;
    en         = 1'b0;
    we         = 1'b0;
    addr       = '0;
    dataW      = '0;
    finish     = 1'b0;
    wr         = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RD;
      end
      RD: begin
        en         = 1'b1;
        addr       = 16'(IN_BASE) + 16'(k);
        state_next = WR;
      end
      WR: begin
        wr         = (k >= CW'(WW + 1));
        state_next = (k < CW'(NW - 1)) ? RD : FLUSH;
      end
      FLUSH: begin
        wr = 1'b1;
        if (m == CW'(NW - 1)) state_next = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (wr) begin
      en    = 1'b1;
      we    = 1'b1;
      addr  = 16'(OUT_BASE) + 16'(m);
      dataW = out_word;
    end
  end

  // Input index, output index and output row/column trackers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k    <= '0;
      m    <= '0;
      orow <= '0;
      ocol <= '0;
    end else if (state == IDLE) begin
      k    <= '0;
      m    <= '0;
      orow <= '0;
      ocol <= '0;
    end else begin
      if (state == WR) k <= k + CW'(1);
      if (wr) begin
        m <= m + CW'(1);
        if (ocol == LW'(WW - 1)) begin
          ocol <= '0;
          orow <= orow + RW'(1);
        end else begin
          ocol <= ocol + LW'(1);
        end
      end
    end
  end

  // Newest word: live read data in WR, zero padding while flushing
  always_comb begin
    cur = (state == WR) ? dataR : 32'h0;
  end

  // Word history; hist[d-1] holds the word d positions behind cur
  always_ff @(posedge clk) begin
    if (state == WR || state == FLUSH) begin
      hist[0] <= cur;
      for (int i = 1; i < int'(HD); i++) hist[i] <= hist[i-1];
    end
  end

  // Six-pixel strips (columns 4j-1..4j+4) for the rows above, at and below the output word
  always_comb begin
    strip_t = {hist[2*WW-1][7:0], hist[2*WW], hist[2*WW+1][31:24]};
    strip_m = {hist[WW-1][7:0],   hist[WW],   hist[WW+1][31:24]};
    strip_b = {cur[7:0],          hist[0],    hist[1][31:24]};
  end

  // Four-lane kernel with border masking
  always_comb begin
    logic [7:0] mag;
    out_word = '0;
    for (int b = 0; b < 4; b++) begin
      mag = sobel3x3(strip_t[8*b +: 8], strip_t[8*b+8 +: 8], strip_t[8*b+16 +: 8],
                     strip_m[8*b +: 8], strip_m[8*b+16 +: 8],
                     strip_b[8*b +: 8], strip_b[8*b+8 +: 8], strip_b[8*b+16 +: 8]);
`ifdef ACC_THRESH_EN
      out_word[8*b +: 8] = (mag >= thresh) ? 8'hFF : 8'h00;
`else
      out_word[8*b +: 8] = mag;
`endif
    end
    if (orow == '0 || orow == RW'(IMG_H - 1)) out_word = '0;
    if (ocol == '0)             out_word[7:0]   = 8'h00;
    if (ocol == LW'(WW - 1))    out_word[31:24] = 8'h00;
  end

endmodule

// File: tb/tb_acc_stream.sv
// Directed bench for acc_stream on an 8x4 image with non-zero base addresses.
module tb_acc_stream;

  localparam int TW    = 8;
  localparam int TH    = 4;
  localparam int WWB   = TW / 4;
  localparam int NB    = TH * WWB;
  localparam int IN_B  = 4;
  localparam int OUT_B = 40;
  localparam int FIN_CYC = 2 * NB + WWB + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr;
  logic [31:0] dataR;
  logic [31:0] dataW;
  logic        en, we, start, finish;
`ifdef ACC_THRESH_EN
  logic [7:0]  thresh = 8'd100;
`endif

  acc_stream #(.IMG_W(TW), .IMG_H(TH), .IN_BASE(IN_B), .OUT_BASE(OUT_B)) dut (
    .clk(clk), .reset(reset), .addr(addr), .dataR(dataR), .dataW(dataW),
    .en(en), .we(we), .start(start), .finish(finish)
`ifdef ACC_THRESH_EN
    , .thresh(thresh)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  pix [TH][TW];
  logic [31:0] img [NB];
  logic [31:0] exp_w [NB];
  logic [31:0] out_mem [NB];
  int          rcnt [NB];
  int          wcnt [NB];
  int          bad_acc, order_err, nwr, last_w, acc_cnt;
  logic        clr = 1'b0;

  // Memory: one-cycle read latency, out-of-region reads return a marker
  always @(posedge clk) begin
    if (en && !we && int'(addr) >= IN_B && int'(addr) < IN_B + NB)
      dataR <= img[int'(addr) - IN_B];
    else
      dataR <= 32'hDEADBEEF;
  end

  // Access monitor and output capture
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NB; i++) begin
        rcnt[i] = 0; wcnt[i] = 0; out_mem[i] = 32'hA5A5A5A5;
      end
      bad_acc = 0; order_err = 0; nwr = 0; last_w = 0; acc_cnt = 0;
    end else if (en) begin
      acc_cnt++;
      if (we) begin
        if (int'(addr) >= OUT_B && int'(addr) < OUT_B + NB) begin
          wcnt[int'(addr) - OUT_B]++;
          out_mem[int'(addr) - OUT_B] = dataW;
        end else bad_acc++;
        if (nwr > 0 && int'(addr) <= last_w) order_err++;
        last_w = int'(addr);
        nwr++;
      end else begin
        if (int'(addr) >= IN_B && int'(addr) < IN_B + NB) rcnt[int'(addr) - IN_B]++;
        else bad_acc++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic pack_img();
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < WWB; c++)
        img[r*WWB + c] = {pix[r][4*c+3], pix[r][4*c+2], pix[r][4*c+1], pix[r][4*c]};
  endtask

  function automatic int px(input int r, input int c);
    return int'(pix[r][c]);
  endfunction

  function automatic logic [7:0] ref_px(input int r, input int c);
    int gx, gy, mag;
    if (r == 0 || r == TH-1 || c == 0 || c == TW-1) return 8'h00;
    gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
    gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
`ifdef ACC_THRESH_EN
    return (mag >= int'(thresh)) ? 8'hFF : 8'h00;
`else
    return 8'(mag);
`endif
  endfunction

  task automatic ref_image();
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < WWB; c++)
        exp_w[r*WWB + c] = {ref_px(r,4*c+3), ref_px(r,4*c+2), ref_px(r,4*c+1), ref_px(r,4*c)};
  endtask

  task automatic set_rows12(input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 0; i < NB; i++) exp_w[i] = 32'h0;
    exp_w[2] = w0; exp_w[3] = w1; exp_w[4] = w0; exp_w[5] = w1;
  endtask

  task automatic check_image(input string name);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s out[%0d]", name, i), out_mem[i], exp_w[i]);
      chk($sformatf("%s wcnt[%0d]", name, i), 32'(wcnt[i]), 32'd1);
      chk($sformatf("%s rcnt[%0d]", name, i), 32'(rcnt[i]), 32'd1);
    end
    chk({name, " bad_acc"}, 32'(bad_acc), 32'd0);
    chk({name, " order"}, 32'(order_err), 32'd0);
  endtask

  // One start pulse; returns the cycle of finish (first RD = cycle 1) and en-low cycles
  task automatic do_run(output int fin_cyc, output int en_low);
    int cyc;
    @(negedge clk); start = 1'b1; clr = 1'b1;
    @(negedge clk); start = 1'b0; clr = 1'b0;
    cyc = 1; en_low = 0; fin_cyc = -1;
    while (cyc < 200) begin
      if (finish) begin fin_cyc = cyc; break; end
      if (!en) en_low++;
      @(negedge clk); cyc++;
    end
  endtask

  task automatic run_and_check(input string name);
    int fc, el;
    do_run(fc, el);
    chk({name, " finish cycle"}, 32'(fc), 32'(FIN_CYC));
    chk({name, " en-low cycles"}, 32'(el), 32'(WWB + 1));
    check_image(name);
  endtask

  initial begin
    int fc, el, cyc, acc0;
    start = 1'b0;
    // reset state
    #3 reset = 1'b0;
    #1;
    chk("rst en", 32'(en), 32'd0);
    chk("rst we", 32'(we), 32'd0);
    chk("rst finish", 32'(finish), 32'd0);
    chk("rst addr", 32'(addr), 32'd0);
    chk("rst dataW", dataW, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // uniform 0x80 -> all zero
    for (int r = 0; r < TH; r++) for (int c = 0; c < TW; c++) pix[r][c] = 8'h80;
    pack_img();
    for (int i = 0; i < NB; i++) exp_w[i] = 32'h0;
    run_and_check("uniform");

    // vertical step: columns 0-3 dark, 4-7 bright
    for (int r = 0; r < TH; r++) for (int c = 0; c < TW; c++) pix[r][c] = (c >= 4) ? 8'hFF : 8'h00;
    pack_img();
    chk("vstep packing", img[1], 32'hFFFFFFFF);
    set_rows12(32'hFF000000, 32'h000000FF);
    run_and_check("vstep");

    // horizontal step: rows 0-1 dark, 2-3 bright
    for (int r = 0; r < TH; r++) for (int c = 0; c < TW; c++) pix[r][c] = (r >= 2) ? 8'hFF : 8'h00;
    pack_img();
    set_rows12(32'hFFFFFF00, 32'h00FFFFFF);
    run_and_check("hstep");

    // horizontal ramp, step 30: |Gx| = 240 on the interior
    for (int r = 0; r < TH; r++) for (int c = 0; c < TW; c++) pix[r][c] = 8'(30 * c);
    pack_img();
    chk("ramp packing w0", img[0], 32'h5A3C1E00);
    chk("ramp packing w1", img[1], 32'hD2B49678);
`ifdef ACC_THRESH_EN
    set_rows12(32'hFFFFFF00, 32'h00FFFFFF);
    run_and_check("ramp t100");
    thresh = 8'd250;
    set_rows12(32'h00000000, 32'h00000000);
    run_and_check("ramp t250");
    thresh = 8'd100;
`else
    set_rows12(32'hF0F0F000, 32'h00F0F0F0);
    run_and_check("ramp");
`endif

    // pseudo-random image against the pixel-array reference
    for (int r = 0; r < TH; r++) for (int c = 0; c < TW; c++) pix[r][c] = 8'($urandom_range(0, 255));
    pack_img();
    ref_image();
    run_and_check("random");

    // reset during WR at k=5 (cycle 12, writing output word 2)
    @(negedge clk); start = 1'b1; clr = 1'b1;
    @(negedge clk); start = 1'b0; clr = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre-reset en", 32'(en), 32'd1);
    chk("pre-reset we", 32'(we), 32'd1);
    chk("pre-reset addr", 32'(addr), 32'(OUT_B + 2));
    reset = 1'b0;
    #1;
    chk("midrst en", 32'(en), 32'd0);
    chk("midrst we", 32'(we), 32'd0);
    chk("midrst finish", 32'(finish), 32'd0);
    acc0 = acc_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst no access", 32'(acc_cnt - acc0), 32'd0);
    run_and_check("after reset");

    // start held high across two back-to-back runs (vertical step)
    for (int r = 0; r < TH; r++) for (int c = 0; c < TW; c++) pix[r][c] = (c >= 4) ? 8'hFF : 8'h00;
    pack_img();
    set_rows12(32'hFF000000, 32'h000000FF);
    @(negedge clk); start = 1'b1; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    cyc = 1; fc = -1;
    while (cyc < 200) begin
      if (finish) begin fc = cyc; break; end
      @(negedge clk); cyc++;
    end
    chk("held run1 finish cycle", 32'(fc), 32'(FIN_CYC));
    check_image("held run1");
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("held idle en", 32'(en), 32'd0);
    @(negedge clk);
    chk("held run2 RD en", 32'(en), 32'd1);
    chk("held run2 RD we", 32'(we), 32'd0);
    chk("held run2 RD addr", 32'(addr), 32'(IN_B));
    start = 1'b0;
    cyc = 1; fc = -1;
    while (cyc < 200) begin
      if (finish) begin fc = cyc; break; end
      @(negedge clk); cyc++;
    end
    chk("held run2 finish cycle", 32'(fc), 32'(FIN_CYC));
    check_image("held run2");
    @(negedge clk);
    @(negedge clk);
    chk("held no third run", 32'(en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
